// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_n packet multiplexer.
//   state_e      : FSM states (IDLE = no packet open, BUSY = locked to one channel)
//   N_MIN/N_MAX  : legal range of the channel-count parameter N
//   W_MIN/W_MAX  : legal range of the per-channel data width W
package stream_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  localparam int W_MIN = 1;
  localparam int W_MAX = 64;

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_arb.sv
// Round-robin candidate search for stream_mux_n.
// Finds the first asserted bit of valid_i, starting one above rr_ptr_i and
// wrapping around, so the most recently granted channel has lowest priority.
//   valid_i     : per-channel valid vector
//   rr_ptr_i    : index of the most recently granted channel
//   grant_o     : index of the chosen channel (meaningful only when any_valid_o=1)
//   any_valid_o : at least one channel is valid
module stream_mux_rr_arb #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [CW-1:0] rr_ptr_i,
  output logic [CW-1:0] grant_o,
  output logic          any_valid_o
);

  always_comb begin
    int idx;
    // NOTE: every combinationally driven variable gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    idx         = 0;
    grant_o     = '0;
    any_valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr_i) + k) % N;
      if (!any_valid_o && valid_i[idx]) begin
        any_valid_o = 1'b1;
        grant_o     = CW'(idx);
      end
    end
  end

endmodule : stream_mux_rr_arb

// File: rtl/stream_mux_n.sv
// N-to-1 packet-aware stream multiplexer with a one-beat output register.
// In IDLE one candidate channel is offered ready each cycle; a multi-beat
// packet locks the mux to its channel (BUSY) until the beat carrying in_last.
// Candidate selection:
//   default               : candidate = selection_line (no grant if >= N)
//   STREAM_MUX_RR_EN set  : round-robin over in_valid, selection_line ignored
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_data         : N*W packed channel data, channel i at [i*W +: W]
//   in_valid/last   : per-channel valid and end-of-packet
//   in_ready        : per-channel ready (at most one bit set)
//   selection_line  : explicit channel select (fixed mode only)
//   out_data/valid/last/chan : registered output beat and its source channel
//   out_ready       : downstream ready
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int CW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic [CW-1:0]  selection_line,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [CW-1:0]  out_chan,
  input  logic           out_ready
);

  if (N < N_MIN || N > N_MAX || W < W_MIN || W > W_MAX) begin : g_bad_param
    $error("stream_mux_n: parameter N or W out of range");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] lock_chan_q, lock_chan_d;
  logic [W-1:0]  out_data_q;
  logic          out_valid_q, out_last_q;
  logic [CW-1:0] out_chan_q;

  logic [CW-1:0] cand;
  logic          cand_ok;
  logic          can_load;
  logic          accept;
  logic          sel_last;
  logic [W-1:0]  sel_data;

  assign can_load = !out_valid_q || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] rr_grant;
  logic          rr_any;

  stream_mux_rr_arb #(.N(N), .CW(CW)) u_rr_arb (
    .valid_i     (in_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (rr_grant),
    .any_valid_o (rr_any)
  );
`endif

  // Candidate: the locked channel in BUSY, otherwise the mode's IDLE choice.
  always_comb begin
    cand    = lock_chan_q;
    cand_ok = 1'b1;
    if (state_q == IDLE) begin
`ifdef STREAM_MUX_RR_EN
      cand    = rr_grant;
      cand_ok = rr_any;
`else
      cand    = selection_line;
      cand_ok = (int'(selection_line) < N);
`endif
    end
  end

  // Output process: ready to the candidate only; gated by rst_n so that no
  // beat is handshaken while reset is held.
  always_comb begin
    in_ready = '0;
    accept   = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_ok && cand == CW'(i)) begin
        in_ready[i] = can_load && rst_n;
        accept      = in_valid[i] && can_load && rst_n;
        sel_last    = in_last[i];
        sel_data    = in_data[i*W +: W];
      end
    end
  end

  // Next-state process.
  always_comb begin
    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    case (state_q)
      IDLE: if (accept && !sel_last) begin
        state_d     = BUSY;
        lock_chan_d = cand;
      end
      BUSY: if (accept && sel_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_chan_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
    end
  end

`ifdef STREAM_MUX_RR_EN
  // Pointer moves only on the first beat of a packet (accepted in IDLE).
  assign rr_ptr_d = (accept && state_q == IDLE) ? cand : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= CW'(N - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // One-beat output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
      out_chan_q  <= cand;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule : stream_mux_n
